// File: rtl/alu_seq_pkg.sv
// Shared op codes, FSM states and iterative-unit modes for the sequential ALU.
package alu_seq_pkg;

  localparam logic [3:0] OP_PASS = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_SHR  = 4'b0011;
  localparam logic [3:0] OP_SHL  = 4'b0100;
  localparam logic [3:0] OP_NAND = 4'b0101;
  localparam logic [3:0] OP_CMP  = 4'b0110;
  localparam logic [3:0] OP_MAX  = 4'b0111;
  localparam logic [3:0] OP_MUL  = 4'b1000;

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_MUL, ST_DONE} state_t;

  typedef enum logic [1:0] {IT_SHR, IT_SHL, IT_MUL} iter_kind_t;

endpackage

// File: rtl/alu_seq_iter.sv
// Iterative shift (and, with ALU_SEQ_MUL_EN, shift-add multiply) datapath, one bit per cycle.
// done pulses on the last step; res_lo/res_hi carry that step's result for the caller to register.
module alu_seq_iter
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH),
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  iter_kind_t       kind,
  input  logic [WIDTH-1:0] a,
  input  logic [SHW-1:0]   amt,
`ifdef ALU_SEQ_MUL_EN
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res_hi,
`endif
  output logic             done,
  output logic [WIDTH-1:0] res_lo
);

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  iter_kind_t       kind_q, kind_d;
  logic             run_q, run_d;
`ifdef ALU_SEQ_MUL_EN
  // Multiplier lives in acc_q and is consumed from the LSB while the product shifts in.
  logic [WIDTH-1:0] hi_q, hi_d, mcand_q, mcand_d;
  logic [WIDTH:0]   sum;
`endif

  always_comb begin
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    kind_d = kind_q;
    run_d  = run_q;
    done   = 1'b0;
`ifdef ALU_SEQ_MUL_EN
    hi_d    = hi_q;
    mcand_d = mcand_q;
    sum     = '0;
`endif
    if (start) begin
      acc_d  = a;
      cnt_d  = CW'(amt);
      kind_d = kind;
      run_d  = 1'b1;
`ifdef ALU_SEQ_MUL_EN
      hi_d    = '0;
      mcand_d = a;
      if (kind == IT_MUL) begin
        acc_d = b;
        cnt_d = CW'(WIDTH);
      end
`endif
    end else if (run_q) begin
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        run_d = 1'b0;
        done  = 1'b1;
      end
      case (kind_q)
        IT_SHR: acc_d = acc_q >> 1;
        IT_SHL: acc_d = acc_q << 1;
`ifdef ALU_SEQ_MUL_EN
        IT_MUL: begin
          sum           = {1'b0, hi_q} + (acc_q[0] ? {1'b0, mcand_q} : '0);
          {hi_d, acc_d} = {sum, acc_q[WIDTH-1:1]};
        end
`endif
        default: acc_d = acc_q;
      endcase
    end
  end

  assign res_lo = acc_d;
`ifdef ALU_SEQ_MUL_EN
  assign res_hi = hi_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      kind_q <= IT_SHR;
      run_q  <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      hi_q    <= '0;
      mcand_q <= '0;
`endif
    end else begin
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      kind_q <= kind_d;
      run_q  <= run_d;
`ifdef ALU_SEQ_MUL_EN
      hi_q    <= hi_d;
      mcand_q <= mcand_d;
`endif
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked multi-cycle ALU: single-cycle ops, iterative shifts, registered result and flags.
// Define ALU_SEQ_MUL_EN to add the iterative unsigned multiply on op 1000.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic [SHW-1:0]   shift_amount,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             sign,
  output logic             zero,
  output logic             equal,
  output logic             overflow,
  output logic             busy
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             zero_q, zero_d, equal_q, equal_d, ovf_q, ovf_d;
  logic             a_msb_q, a_msb_d;

  logic             accept, load;
  logic [WIDTH-1:0] res;
  logic             res_eq, res_ov;
  logic             iter_start, iter_done;
  iter_kind_t       iter_kind;
  logic [WIDTH-1:0] iter_lo;
`ifdef ALU_SEQ_MUL_EN
  logic [WIDTH-1:0] iter_hi;
`endif

  assign in_ready  = (state_q == ST_IDLE) && !rst;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_SHIFT) || (state_q == ST_MUL);
  assign data_out  = data_q;
  assign sign      = data_q[WIDTH-1];
  assign zero      = zero_q;
  assign equal     = equal_q;
  assign overflow  = ovf_q;

  always_comb begin
    state_d    = state_q;
    a_msb_d    = a_msb_q;
    load       = 1'b0;
    res        = '0;
    res_eq     = 1'b0;
    res_ov     = 1'b0;
    iter_start = 1'b0;
    iter_kind  = IT_SHR;
    case (state_q)
      ST_IDLE: if (accept) begin
        a_msb_d = data1[WIDTH-1];
        load    = 1'b1;
        case (op)
          OP_PASS: res = data2;
          OP_ADD: begin
            res    = data1 + data2;
            res_ov = (data1[WIDTH-1] == data2[WIDTH-1]) && (res[WIDTH-1] != data1[WIDTH-1]);
          end
          OP_SUB: begin
            res    = data1 - data2;
            res_ov = (data1[WIDTH-1] != data2[WIDTH-1]) && (res[WIDTH-1] != data1[WIDTH-1]);
          end
          OP_NAND: res = ~(data1 & data2);
          OP_CMP: begin
            res    = data1;
            res_eq = (data1 == data2);
          end
          OP_MAX: res = (data1 > data2) ? data1 : data2;
          OP_SHR, OP_SHL: begin
            // A zero count finishes at once; overflow is then data1 ^ data1 = 0.
            res = data1;
            if (shift_amount != '0) begin
              load       = 1'b0;
              iter_start = 1'b1;
              iter_kind  = (op == OP_SHR) ? IT_SHR : IT_SHL;
              state_d    = ST_SHIFT;
            end
          end
`ifdef ALU_SEQ_MUL_EN
          OP_MUL: begin
            load       = 1'b0;
            iter_start = 1'b1;
            iter_kind  = IT_MUL;
            state_d    = ST_MUL;
          end
`endif
          default: res = '0;
        endcase
      end
      ST_SHIFT: if (iter_done) begin
        load   = 1'b1;
        res    = iter_lo;
        res_ov = a_msb_q ^ iter_lo[WIDTH-1];
      end
`ifdef ALU_SEQ_MUL_EN
      ST_MUL: if (iter_done) begin
        load   = 1'b1;
        res    = iter_lo;
        res_ov = |iter_hi;
      end
`endif
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (load) state_d = ST_DONE;
  end

  always_comb begin
    data_d  = data_q;
    zero_d  = zero_q;
    equal_d = equal_q;
    ovf_d   = ovf_q;
    if (load) begin
      data_d  = res;
      zero_d  = (res == '0);
      equal_d = res_eq;
      ovf_d   = res_ov;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      zero_q  <= 1'b0;
      equal_q <= 1'b0;
      ovf_q   <= 1'b0;
      a_msb_q <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      zero_q  <= zero_d;
      equal_q <= equal_d;
      ovf_q   <= ovf_d;
      a_msb_q <= a_msb_d;
    end
  end

  alu_seq_iter #(.WIDTH(WIDTH), .SHW(SHW)) u_iter (
    .clk    (clk),
    .rst    (rst),
    .start  (iter_start),
    .kind   (iter_kind),
    .a      (data1),
    .amt    (shift_amount),
`ifdef ALU_SEQ_MUL_EN
    .b      (data2),
    .res_hi (iter_hi),
`endif
    .done   (iter_done),
    .res_lo (iter_lo)
  );

endmodule

// File: tb/tb_alu_seq.sv
// Directed plus randomized bench for alu_seq (WIDTH=16) against an arithmetic reference model.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [3:0]  op;
  logic [15:0] data1, data2, data_out;
  logic [3:0]  shift_amount;
  logic        sign, zero, equal, overflow, busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .data1(data1), .data2(data2), .shift_amount(shift_amount), .out_valid(out_valid),
    .out_ready(out_ready), .data_out(data_out), .sign(sign), .zero(zero), .equal(equal),
    .overflow(overflow), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: results from signed/unsigned integer arithmetic on the op definitions.
  task automatic model(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] amt, output logic [15:0] r, output logic ov,
                       output logic eq, output int lat);
    int s;
    longint unsigned p;
    r = 16'h0; ov = 1'b0; eq = 1'b0; lat = 1;
    case (o)
      4'd0: r = b;
      4'd1: begin s = int'($signed(a)) + int'($signed(b)); r = s[15:0]; ov = (s > 32767) || (s < -32768); end
      4'd2: begin s = int'($signed(a)) - int'($signed(b)); r = s[15:0]; ov = (s > 32767) || (s < -32768); end
      4'd3: begin r = a >> amt; ov = a[15] ^ r[15]; lat = int'(amt) + 1; end
      4'd4: begin p = longint'(a) * (64'd1 << amt); r = p[15:0]; ov = a[15] ^ r[15]; lat = int'(amt) + 1; end
      4'd5: r = ~(a & b);
      4'd6: begin r = a; eq = (a == b); end
      4'd7: r = (int'(a) > int'(b)) ? a : b;
`ifdef ALU_SEQ_MUL_EN
      4'd8: begin p = longint'(a) * longint'(b); r = p[15:0]; ov = (p >= 64'h10000); lat = 17; end
`endif
      default: r = 16'h0;
    endcase
  endtask

  // Issue one op, measure latency, check outputs, hold out_ready low for 'hold' cycles, then retire.
  task automatic run_op(input string tag, input logic [3:0] o, input logic [15:0] a,
                        input logic [15:0] b, input logic [3:0] amt, input int hold);
    logic [15:0] er;
    logic eov, eeq;
    int elat, lat;
    model(o, a, b, amt, er, eov, eeq, elat);
    @(negedge clk);
    in_valid = 1'b1; op = o; data1 = a; data2 = b; shift_amount = amt;
    check({tag, ".in_ready"}, in_ready, 1);
    @(negedge clk);
    // Junk requests while not ready must be ignored.
    op = 4'($urandom); data1 = 16'($urandom); data2 = 16'($urandom); shift_amount = 4'($urandom);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({tag, ".latency"}, lat, elat);
    check({tag, ".data"}, data_out, er);
    check({tag, ".flags"}, {sign, zero, equal, overflow}, {er[15], er == 16'h0, eeq, eov});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, ".hold"}, {out_valid, in_ready, data_out}, {1'b1, 1'b0, er});
    end
    out_ready = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, ".retire"}, {out_valid, in_ready}, 2'b01);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    op = 4'h0; data1 = 16'h0; data2 = 16'h0; shift_amount = 4'h0;
    #12;
    check("reset", {in_ready, out_valid, data_out, sign, zero, equal, overflow, busy}, 0);
    @(negedge clk); rst = 1'b0;
    #1 check("reset_release.in_ready", in_ready, 1);

    run_op("add_ovf", 4'd1, 16'h7FFF, 16'h0001, 4'd0, 0);
    run_op("sub_zero", 4'd2, 16'h1234, 16'h1234, 4'd0, 0);
    run_op("cmp_eq", 4'd6, 16'h1234, 16'h1234, 4'd0, 0);
    run_op("shl3", 4'd4, 16'h4001, 16'h0000, 4'd3, 0);
    run_op("shl0", 4'd4, 16'hBEEF, 16'h0000, 4'd0, 0);
    run_op("shr15", 4'd3, 16'h8000, 16'h0000, 4'd15, 0);
    run_op("max_hold", 4'd7, 16'h8000, 16'h7FFF, 4'd0, 5);
    run_op("op8", 4'd8, 16'h0100, 16'h0100, 4'd0, 0);
    run_op("op15", 4'd15, 16'hFFFF, 16'hFFFF, 4'd0, 0);

    // Abort a long shift part-way through.
    @(negedge clk);
    in_valid = 1'b1; op = 4'd3; data1 = 16'hFFFF; shift_amount = 4'd15;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_shift.busy", busy, 1);
    rst = 1'b1;
    #1 check("mid_shift.reset", {in_ready, out_valid, data_out, sign, zero, equal, overflow, busy}, 0);
    @(negedge clk); rst = 1'b0;
    run_op("after_reset", 4'd1, 16'h0003, 16'h0004, 4'd0, 0);

    for (int k = 0; k < 30; k++) begin
      run_op("rand", 4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom),
             4'($urandom), int'($urandom_range(0, 2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked, multi-cycle successor to the 16-bit combinational ALU in the CPU datapath.
- Adds generic WIDTH, valid/ready flow control and registered results/flags.
- Shifts are iterative, one bit per cycle; an iterative multiply is optional.
- Sits between register-file read and writeback; the control unit stalls on in_ready/out_valid.

Parameters:
- WIDTH, 16, data width in bits; must be at least 4.
- SHW, $clog2(WIDTH), width of the shift-amount field.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept an operation.
- op  in  4  operation code.
- data1  in  WIDTH  operand A.
- data2  in  WIDTH  operand B.
- shift_amount  in  SHW  shift count.
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer accepts the result.
- data_out  out  WIDTH  registered result.
- sign  out  1  data_out[WIDTH-1].
- zero  out  1  data_out == 0.
- equal  out  1  compare result.
- overflow  out  1  overflow flag.
- busy  out  1  state is SHIFT or MUL.

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high. On reset: state=IDLE, in_ready=0 while rst is asserted, out_valid=0, data_out=0, sign=0, zero=0, equal=0, overflow=0, busy=0.
- FSM has states IDLE, SHIFT, MUL, DONE.
  - in_ready = (state==IDLE).
  - Accept when in_valid && in_ready; op and operands are captured in that cycle.
- Single-cycle ops (0000-0010, 0101-0111): IDLE->DONE. out_valid is high the cycle after accept (latency 1).
  - 0000: result = data2.
  - 0001: data1+data2, mod 2^WIDTH. overflow = signed overflow: both operand signs equal and the result sign differs.
  - 0010: data1-data2. overflow = operand signs differ and the result sign differs from data1.
  - 0101: ~(data1 & data2).
  - 0110: result = data1; equal = (data1==data2).
  - 0111: unsigned max(data1, data2).
- Shifts:
  - 0011 is logical right shift; 0100 is logical left shift.
  - Accept with shift_amount=0: go directly to DONE, result = data1.
  - Otherwise IDLE->SHIFT. Shift one bit per cycle with a down-counter; go to DONE when the counter reaches 0. Latency is shift_amount+1 cycles.
  - overflow = data1[WIDTH-1] XOR result[WIDTH-1].
- Ops 1000-1111 without the optional feature: IDLE->DONE, result 0, all flags 0 except zero=1.
- equal is 0 for every op except 0110. overflow is 0 for every op not listed above.
- sign and zero are always derived from the final registered data_out.
- DONE: hold data_out, flags and out_valid=1 stable until out_ready=1. Then go to IDLE and clear out_valid the next cycle.
  - Back-to-back throughput: one op per latency+1 cycles.
- in_valid asserted while not ready is ignored, with no side effects. Operand inputs are don't-care outside the accept cycle.
- rst asserted mid-SHIFT, mid-MUL or in DONE: abort immediately to the reset values; the pending result is lost.

Optional Feature:
- Macro ALU_SEQ_MUL_EN.
- When defined, op 1000 = unsigned multiply by shift-add, one bit per cycle. IDLE->MUL for WIDTH cycles, then DONE; latency WIDTH+1.
  - data_out = low WIDTH bits of the product.
  - overflow = (high WIDTH bits != 0).
  - busy is high during MUL.
- When undefined, op 1000 behaves like the other ops 1000-1111 (result 0, zero=1). No multiplier logic is synthesised.

Decomposition:
- Package alu_seq_pkg:
  - op-code localparams: OP_PASS, OP_ADD, OP_SUB, OP_SHR, OP_SHL, OP_NAND, OP_CMP, OP_MAX, OP_MUL.
  - state enum: ST_IDLE, ST_SHIFT, ST_MUL, ST_DONE.
- One natural sub-module, alu_seq_iter: the iterative shift/multiply datapath, with accumulator, counter and done pulse.
- The top level holds the FSM, the single-cycle ops and the flag registers.

Test Plan (WIDTH=16):
- op=0001, data1=0x7FFF, data2=0x0001 -> one cycle later out_valid=1, data_out=0x8000, overflow=1, sign=1, zero=0.
- op=0010, data1=data2=0x1234 -> data_out=0x0000, zero=1, overflow=0. A separate op=0110 with the same operands -> equal=1, data_out=0x1234.
- op=0100, data1=0x4001, shift_amount=3 -> out_valid exactly 4 cycles after accept, data_out=0x0008, overflow=0. Then shift_amount=0 -> latency 1, data_out=data1.
- Hold out_ready=0 for 5 cycles after op=0111, data1=0x8000, data2=0x7FFF -> data_out stays 0x8000 and in_ready stays 0; release -> IDLE the next cycle.
- Assert rst during SHIFT with shift_amount=15, mid-count -> all outputs 0 immediately; a new op after release completes correctly.
- With ALU_SEQ_MUL_EN, op=1000, data1=0x0100, data2=0x0100 -> after 17 cycles data_out=0x0000, overflow=1, zero=1. Without the macro -> result 0 and zero=1 after 1 cycle.
